// File: rtl/floatmul_arbiter.sv
// floatmul_arbiter: round-robin arbiter that shares one pipelined float
// multiplier among NUM_REQ requesters. A fixed-latency tag pipeline routes
// each result back to the requester that issued the operation. A
// RUN/DRAIN/HALT state machine lets the block stop issuing and drain.
// Optional feature: define FLOATMUL_ARB_STATS_EN to add grant_cnt, one
// saturating 16-bit accept counter per requester.
//
// Handshake: a request is accepted in a cycle where req_valid[i] and
// req_ready[i] are both high. The accepted operands appear on mul_a/mul_b
// with mul_valid in that same cycle. The response is pushed on
// rsp_valid/rsp_data exactly MUL_LAT cycles later, and it cannot be stalled.
module floatmul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        mul_valid,
  output logic [DATA_W-1:0]           mul_a,
  output logic [DATA_W-1:0]           mul_b,
  input  logic [DATA_W-1:0]           mul_res,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        halt_req,
  output logic                        halted,
  output logic [1:0]                  fsm_state
`ifdef FLOATMUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               accept;
  logic [MUL_LAT-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [MUL_LAT];
  logic               early_busy;

  assign fsm_state = state;

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_valid[IDX_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  // Grant and issue port; rst gates everything so outputs drop at once.
  always_comb begin
    accept    = gnt_found && (state == RUN) && !rst;
    req_ready = '0;
    mul_valid = accept;
    mul_a     = '0;
    mul_b     = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
      mul_a = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      mul_b = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
    end
  end

  // Tag pipeline carrying {valid, owner}; it advances every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) tag_idx[i] <= '0;
    end else begin
      tag_v[0]   <= accept;
      tag_idx[0] <= gnt_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Any op still behind the output stage? The output stage itself is
  // delivered in the current cycle, so it does not hold off HALT.
  always_comb begin
    early_busy = 1'b0;
    for (int i = 0; i < MUL_LAT - 1; i++) early_busy = early_busy | tag_v[i];
  end

  // Response routing from the last tag stage.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (tag_v[MUL_LAT-1]) begin
      rsp_valid[tag_idx[MUL_LAT-1]] = 1'b1;
      rsp_data = mul_res;
    end
  end

  // Round-robin pointer: moves past the granted index only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      if (gnt_idx == IDX_W'(NUM_REQ - 1)) ptr <= '0;
      else                                ptr <= gnt_idx + 1'b1;
    end
  end

  // RUN/DRAIN/HALT state machine with registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!halt_req) begin
            state <= RUN;
          end else if (!early_busy) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FLOATMUL_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  // Per-requester accept counters, saturating at 0xFFFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (accept && cnt[gnt_idx] != 16'hFFFF) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + 16'd1;
    end
  end

  // Pack counters onto the flat output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: doc/floatmul_arbiter.md
FLOATMUL_ARBITER -- requirements
Module: floatmul_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one float multiplier (2..8).
REQ-002 Parameter DATA_W, default 32: operand and result width.
REQ-003 Parameter MUL_LAT, default 3: fixed multiplier latency in cycles (1..8).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  per-requester operation request.
REQ-007 req_a, req_b  input  NUM_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 req_ready  output  NUM_REQ  one-hot grant; accept occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 mul_valid, mul_a, mul_b  output  1, DATA_W, DATA_W  issue port to the multiplier.
REQ-010 mul_res  input  DATA_W  multiplier result, valid MUL_LAT cycles after the matching issue.
REQ-011 rsp_valid  output  NUM_REQ  one-hot; marks the owner of rsp_data; no backpressure.
REQ-012 rsp_data  output  DATA_W  result routed to the owning requester.
REQ-013 halt_req  input  1  request to stop issuing and drain.
REQ-014 halted  output  1  high when drained and stopped.

Function
REQ-015 The arbiter SHALL grant at most one requester per cycle, round-robin, starting the search at the index after the last granted requester.
REQ-016 req_ready SHALL be combinational from req_valid, the round-robin pointer and the state, and SHALL be all-zero unless the state is RUN.
REQ-017 On accept, mul_valid SHALL be high in the same cycle, with mul_a/mul_b equal to the granted requester's operands.
REQ-018 A MUL_LAT-deep tag pipeline SHALL carry {valid, requester index}; rsp_valid[idx] SHALL rise exactly MUL_LAT cycles after the accept, and rsp_data SHALL equal mul_res in that cycle.
REQ-019 Back-to-back accepts SHALL sustain one issue per cycle; the tag pipeline never stalls.
REQ-020 The round-robin pointer SHALL update only on accept; an index wraps from NUM_REQ-1 to 0.
REQ-021 The state machine SHALL have three states: RUN, DRAIN and HALT.
REQ-022 RUN->DRAIN when halt_req=1; DRAIN->HALT when the tag pipeline is empty; HALT->RUN when halt_req=0; DRAIN->RUN when halt_req drops before the pipeline empties.
REQ-023 In DRAIN, in-flight responses SHALL still be delivered; halted SHALL be high only in HALT.
REQ-024 If halt_req rises in the same cycle as a valid request in RUN, that request SHALL still be granted, and the transition to DRAIN occurs at the clock edge.

Reset
REQ-025 Asserting rst SHALL immediately clear req_ready, mul_valid, rsp_valid, the tag pipeline and halted, set the pointer to 0 (requester 0 has highest priority first) and set the state to RUN.
REQ-026 Operations in flight at reset SHALL be discarded; no rsp_valid SHALL be produced for them after reset.
REQ-027 mul_a, mul_b and rsp_data SHALL be 0 while no valid is asserted.

Configuration
REQ-028 With FLOATMUL_ARB_STATS_EN defined, the block SHALL add an output grant_cnt of width NUM_REQ*16: one saturating 16-bit accept counter per requester, cleared by rst and holding at 0xFFFF once reached.
REQ-029 Without FLOATMUL_ARB_STATS_EN, grant_cnt and its counters SHALL be absent.

Verification
REQ-030 Single request: req_valid=0001, a=2.0, b=3.0 (IEEE-754 single) -> req_ready=0001 in the same cycle; rsp_valid=0001 with rsp_data=0x40C00000 after 3 cycles.
REQ-031 All four requesters continuously valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; each rsp_valid arrives in the same order, 3 cycles later.
REQ-032 Raise halt_req with 3 operations in flight -> req_ready=0 immediately; all 3 responses are delivered; halted=1 in the cycle after the last response.
REQ-033 Assert rst with 2 operations in flight -> all outputs are 0 at once; no rsp_valid appears after reset is released.
REQ-034 With FLOATMUL_ARB_STATS_EN, hold requester 2 continuously valid for 70000 accepts -> grant_cnt[2] saturates at 0xFFFF and the other counters stay at 0.
